// File: rtl/ca_pkg.sv
// Shared definitions for the instruction-cache controller and its tag/data array.
package ca_pkg;

  localparam int unsigned TAG_W  = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'h0,
    LOAD  = 2'h1,
    CLEAR = 2'h2
  } ctrl_state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/ca_match.sv
// Parallel tag comparators with one-hot to binary hit-index encoder.
module ca_match #(
  parameter int CACHE_ENTRIES = 8,
  parameter int TAG_WIDTH     = 32,
  parameter int IDX_WIDTH     = 3
) (
  input  logic [CACHE_ENTRIES-1:0]                valid,
  input  logic [CACHE_ENTRIES-1:0][TAG_WIDTH-1:0] tags,
  input  logic [TAG_WIDTH-1:0]                    key,
  output logic [CACHE_ENTRIES-1:0]                match,
  output logic                                    any,
  output logic [IDX_WIDTH-1:0]                    idx
);

  always_comb begin
    match = '0;
    for (int i = 0; i < CACHE_ENTRIES; i++) begin
      match[i] = valid[i] && (tags[i] == key);
    end
  end

  assign any = |match;

  // OR-reduction encoder; correct because match is at most one-hot.
  always_comb begin
    idx = '0;
    for (int i = 0; i < CACHE_ENTRIES; i++) begin
      if (match[i]) begin
        idx = idx | IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/ca_array.sv
// Fully-associative tag/data array with zero-latency lookup and occupancy tracking.
module ca_array
  import ca_pkg::*;
#(
  parameter int CACHE_ENTRIES   = 8,
  parameter int CACHE_ADDR_LEFT = $clog2(CACHE_ENTRIES) - 1,
  parameter int TAG_WIDTH       = int'(TAG_W),
  parameter int DATA_WIDTH      = int'(DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TAG_WIDTH-1:0]     pc,
  input  logic                     cache_read,
  input  logic                     cache_write_,
  input  logic [CACHE_ADDR_LEFT:0] cache_w_addr,
  input  logic                     new_valid,
  input  logic [DATA_WIDTH-1:0]    w_data,
  output logic                     cache_hit,
  output logic                     cache_full,
  output logic [DATA_WIDTH-1:0]    cache_data,
  output logic [CACHE_ADDR_LEFT:0] hit_addr
);

  localparam int unsigned IW = CACHE_ADDR_LEFT + 1;
  localparam int unsigned CW = $clog2(CACHE_ENTRIES + 1);

  logic [CACHE_ENTRIES-1:0]                 valid;
  logic [CACHE_ENTRIES-1:0][TAG_WIDTH-1:0]  tags;
  logic [CACHE_ENTRIES-1:0][DATA_WIDTH-1:0] data;
  logic [CW-1:0]                            count;

  logic [CACHE_ENTRIES-1:0] match;
  logic                     any_match;
  logic [IW-1:0]            match_idx;
  logic [CACHE_ENTRIES-1:0] wsel;
  logic [CACHE_ENTRIES-1:0] valid_next;
  logic [CW-1:0]            count_next;

  ca_match #(
    .CACHE_ENTRIES(CACHE_ENTRIES),
    .TAG_WIDTH    (TAG_WIDTH),
    .IDX_WIDTH    (IW)
  ) u_match (
    .valid(valid),
    .tags (tags),
    .key  (pc),
    .match(match),
    .any  (any_match),
    .idx  (match_idx)
  );

  assign cache_hit  = cache_read && any_match;
  assign cache_data = cache_hit ? data[match_idx] : '0;
  assign hit_addr   = cache_hit ? match_idx : '0;

  assign wsel = CACHE_ENTRIES'(1) << cache_w_addr;

  // Duplicate eviction reuses the lookup match vector, independent of cache_read.
  always_comb begin
    valid_next = valid;
    count_next = count;
    if (!cache_write_) begin
      if (new_valid) begin
        valid_next = valid & ~(match & ~wsel);
        if (!valid[cache_w_addr]) count_next = count_next + CW'(1);
        if (|(match & ~wsel))     count_next = count_next - CW'(1);
      end else if (valid[cache_w_addr]) begin
        count_next = count_next - CW'(1);
      end
      valid_next[cache_w_addr] = new_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= '0;
      tags       <= '0;
      data       <= '0;
      count      <= '0;
      cache_full <= 1'b0;
    end else if (!cache_write_) begin
      valid      <= valid_next;
      count      <= count_next;
      cache_full <= (count_next == CW'(CACHE_ENTRIES));
      if (new_valid) begin
        tags[cache_w_addr] <= pc;
        data[cache_w_addr] <= w_data;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(match));
      assert (count == CW'($countones(valid)));
      assert (cache_full == (&valid));
    end
  end
`endif

endmodule

// File: tb/tb_ca_array.sv
// Directed self-checking bench for ca_array.
module tb_ca_array;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        cache_read;
  logic        cache_write_;
  logic [2:0]  cache_w_addr;
  logic        new_valid;
  logic [31:0] w_data;
  logic        cache_hit;
  logic        cache_full;
  logic [31:0] cache_data;
  logic [2:0]  hit_addr;

  int checks = 0;
  int errors = 0;

  ca_array dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .cache_read  (cache_read),
    .cache_write_(cache_write_),
    .cache_w_addr(cache_w_addr),
    .new_valid   (new_valid),
    .w_data      (w_data),
    .cache_hit   (cache_hit),
    .cache_full  (cache_full),
    .cache_data  (cache_data),
    .hit_addr    (hit_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic nv, input logic [31:0] p, input logic [31:0] d);
    cache_w_addr = a;
    new_valid    = nv;
    pc           = p;
    w_data       = d;
    cache_write_ = 1'b0;
    @(posedge clk);
    #1;
    cache_write_ = 1'b1;
  endtask

  task automatic lookup(input logic [31:0] p);
    cache_read = 1'b1;
    pc         = p;
    #1;
  endtask

  initial begin
    rst = 1'b1; pc = '0; cache_read = 1'b0; cache_write_ = 1'b1;
    cache_w_addr = '0; new_valid = 1'b0; w_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset asserted while a write is pending discards it.
    cache_w_addr = 3'd0; new_valid = 1'b1; pc = 32'h40; w_data = 32'hDEAD;
    cache_write_ = 1'b0;
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    cache_write_ = 1'b1;
    rst = 1'b0;
    lookup(32'h40);
    check("rst_hit",   cache_hit,  1'b0);
    check("rst_full",  cache_full, 1'b0);
    check("rst_data",  cache_data, 32'h0);
    check("rst_addr",  hit_addr,   3'd0);
    check("rst_valid", dut.valid,  8'h00);
    cache_read = 1'b0;

    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 1'b1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i));
      if (i == 6) check("fill_not_full", cache_full, 1'b0);
    end
    check("fill_full", cache_full, 1'b1);
    check("fill_count", dut.count, 4'd8);
    lookup(32'h10C);
    check("fill_hit",  cache_hit,  1'b1);
    check("fill_addr", hit_addr,   3'd3);
    check("fill_data", cache_data, 32'hA003);

    // Rewrite of a valid entry leaves occupancy alone.
    wr(3'd2, 1'b1, 32'h200, 32'hC002);
    check("rewrite_count", dut.count, 4'd8);
    check("rewrite_full",  cache_full, 1'b1);

    cache_read = 1'b0;
    pc = 32'h200;
    #1;
    check("gate_hit",  cache_hit,  1'b0);
    check("gate_data", cache_data, 32'h0);

    // Same-cycle clear and lookup returns pre-edge contents.
    lookup(32'h200);
    cache_w_addr = 3'd2; new_valid = 1'b0; cache_write_ = 1'b0;
    #1;
    check("same_hit",  cache_hit,  1'b1);
    check("same_addr", hit_addr,   3'd2);
    check("same_data", cache_data, 32'hC002);
    @(posedge clk);
    #1;
    cache_write_ = 1'b1;
    check("same_hit_after", cache_hit,  1'b0);
    check("same_count",     dut.count,  4'd7);
    check("same_full",      cache_full, 1'b0);

    // Duplicate tag: entry 1 holds 0x300, entry 5 freed then written with 0x300.
    wr(3'd1, 1'b1, 32'h300, 32'h1111);
    wr(3'd5, 1'b0, 32'h0, 32'h0);
    check("dup_pre_count", dut.count, 4'd6);
    wr(3'd5, 1'b1, 32'h300, 32'hBEEF);
    check("dup_count", dut.count, 4'd6);
    check("dup_valid", dut.valid, 8'hF9);
    lookup(32'h300);
    check("dup_hit",  cache_hit,  1'b1);
    check("dup_addr", hit_addr,   3'd5);
    check("dup_data", cache_data, 32'hBEEF);

    wr(3'd1, 1'b1, 32'h104, 32'hA001);
    wr(3'd2, 1'b1, 32'h108, 32'hA002);
    check("refill_full", cache_full, 1'b1);

    for (int i = 0; i < 8; i++) begin
      cache_read = 1'b1;
      wr(3'(i), 1'b0, 32'h100 + 32'(4 * i), 32'h0);
      check($sformatf("sweep_count%0d", i), dut.count, 64'(7 - i));
      check($sformatf("sweep_full%0d", i), cache_full, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      lookup(32'h100 + 32'(4 * i));
      check($sformatf("sweep_miss%0d", i), cache_hit, 1'b0);
      check($sformatf("sweep_data%0d", i), cache_data, 32'h0);
    end
    lookup(32'h300);
    check("sweep_miss_dup", cache_hit, 1'b0);
    cache_read = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
